fifo_rd_skid: RTL and testbench
===============================

// Module: fifo_rd_skid
// PURPOSE
//  Read-side port for the synchronous fifo (raw r_en_i/r_data_o/empty_o). Converts the fifo's
//  unguarded pop interface into a registered valid/ready stream for downstream consumers.
//  Guarantees the fifo is never popped when empty and that no combinational path exists from
//  out_ready_i to fifo_r_en_o. Two-entry skid buffer sustains one beat per cycle.
// PARAMETERS
//  DATA_WIDTH  32  width of fifo read data and output stream data
//  CNT_WIDTH   16  width of the delivered-beat counter
// PORTS
//  clk          in   1           clock
//  rst_n        in   1           reset, asynchronous, active-low
//  fifo_empty_i in   1           fifo empty_o
//  fifo_data_i  in   DATA_WIDTH  fifo r_data_o (combinational head of fifo)
//  fifo_r_en_o  out  1           fifo r_en_i (pop strobe)
//  flush_i      in   1           synchronous clear of skid contents
//  out_valid_o  out  1           head beat valid
//  out_data_o   out  DATA_WIDTH  head beat data
//  out_ready_i  in   1           consumer accepts head beat
//  level_o      out  2           skid occupancy 0..2
//  xfer_cnt_o   out  CNT_WIDTH   count of accepted beats (out_valid_o && out_ready_i)
// BEHAVIOUR
//  - Reset: slot0/slot1 = 0, level = 0; out_valid_o=0, out_data_o=0, fifo_r_en_o=0,
//    level_o=0, xfer_cnt_o=0.
//  - Occupancy states: EMPTY(0), ONE(1), TWO(2); out_valid_o = (level!=0); out_data_o = slot0.
//  - pop = !fifo_empty_i && !flush_i && (level!=TWO); fifo_r_en_o = pop (combinational from
//    registered level and fifo_empty_i only; never depends on out_ready_i).
//  - Pop captures fifo_data_i in the same cycle as fifo_r_en_o. Latency: fifo non-empty at
//    cycle t with level EMPTY -> out_valid_o=1 at t+1 with that data.
//  - cons = out_valid_o && out_ready_i. Transitions (no flush):
//    EMPTY: pop -> ONE, slot0<=fifo_data_i; else stay.
//    ONE:   pop&cons -> ONE, slot0<=fifo_data_i; pop&!cons -> TWO, slot1<=fifo_data_i;
//           !pop&cons -> EMPTY; else stay.
//    TWO:   no pop; cons -> ONE, slot0<=slot1; else stay.
//  - Order strictly FIFO: slot0 always older than slot1.
//  - Steady stream with ready=1 holds ONE and delivers one beat/cycle.
//  - Downstream stall: fill to TWO, then fifo_r_en_o=0; out_data_o stable while valid&!ready.
//  - flush_i=1: no pop that cycle; level<=EMPTY next cycle regardless of cons; slot data
//    retained (don't-care); fifo contents untouched. cons in flush cycle still counts.
//  - xfer_cnt_o += 1 on each cons; wraps modulo 2^CNT_WIDTH, no saturation.
//  - Async reset mid-stream: skid contents dropped immediately; fifo pointers reset by its own rst_n.
// STRUCTURE
//  - Shared package: occupancy encoding localparams LVL_EMPTY=2'd0, LVL_ONE=2'd1, LVL_TWO=2'd2.
//  - Single flat module; no sub-module. Instantiated beside fifo, connected fifo_r_en_o->r_en_i,
//    r_data_o->fifo_data_i, empty_o->fifo_empty_i.
// TESTING (bench pairs block with fifo DATA_WIDTH=32, FIFO_DEPTH=4)
//  - Reset: rst_n=0 -> all outputs 0; release with fifo empty -> fifo_r_en_o stays 0.
//  - Push 0xA1 at t, ready=1 -> fifo_r_en_o=1 at t+1, out_valid_o=1 data 0xA1 at t+2, xfer_cnt_o=1.
//  - Push 0x10..0x13 back-to-back, ready=1 -> 4 beats on 4 consecutive cycles in order, level_o=1.
//  - Push 0x20..0x23, ready=0 -> level_o=2, fifo_r_en_o=0 thereafter, out_data_o=0x20 stable;
//    raise ready -> 0x20,0x21,0x22,0x23 one per cycle, no drop/duplicate.
//  - level_o=2 then flush_i=1 one cycle -> out_valid_o=0 next cycle, fifo_r_en_o=0 during flush,
//    remaining fifo entries delivered afterwards in order.
//  - CNT_WIDTH=4, 17 accepted beats -> xfer_cnt_o wraps to 1; fifo never reports underflow pop.

Source files
------------

// File: rtl/fifo_rd_skid_pkg.sv
// Shared definitions for the fifo read-side skid buffer: occupancy encoding
// and small helpers used by the skid control logic.
package fifo_rd_skid_pkg;

  // Skid occupancy encoding; the value doubles as the number of held beats.
  localparam logic [1:0] LVL_EMPTY = 2'd0;
  localparam logic [1:0] LVL_ONE   = 2'd1;
  localparam logic [1:0] LVL_TWO   = 2'd2;

  // True when the skid holds at least one beat for the consumer.
  function automatic logic lvl_has_beat(input logic [1:0] lvl);
    return (lvl == LVL_ONE) || (lvl == LVL_TWO);
  endfunction

  // True when the skid can absorb another beat from the fifo this cycle.
  function automatic logic lvl_has_room(input logic [1:0] lvl);
    return (lvl == LVL_EMPTY) || (lvl == LVL_ONE);
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Read-side port for the synchronous fifo. Turns the fifo's raw pop
// interface into a registered valid/ready stream through a two-entry skid
// buffer. The pop strobe depends only on registered occupancy, flush and the
// fifo empty flag, so the consumer's ready never reaches the fifo
// combinationally, and the fifo is never popped while empty.
module fifo_rd_skid
  import fifo_rd_skid_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_r_en_o,
  input  logic                  flush_i,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  input  logic                  out_ready_i,
  output logic [1:0]            level_o,
  output logic [CNT_WIDTH-1:0]  xfer_cnt_o
);

  // slot0 is always the head (oldest) beat, slot1 the younger one.
  logic [1:0]            level;
  logic [1:0]            level_nxt;
  logic [DATA_WIDTH-1:0] slot0;
  logic [DATA_WIDTH-1:0] slot1;
  logic [DATA_WIDTH-1:0] slot0_nxt;
  logic [DATA_WIDTH-1:0] slot1_nxt;
  logic [CNT_WIDTH-1:0]  xfer_cnt;
  logic                  pop;
  logic                  cons;

  // Pop only with room in the skid, data in the fifo and no flush pending.
  assign pop  = !fifo_empty_i && !flush_i && lvl_has_room(level);
  assign cons = out_valid_o && out_ready_i;

  assign fifo_r_en_o = pop;
  assign out_valid_o = lvl_has_beat(level);
  assign out_data_o  = slot0;
  assign level_o     = level;
  assign xfer_cnt_o  = xfer_cnt;

  // Next occupancy and slot contents; flush empties the skid but leaves the
  // slot data untouched since it is never presented without valid.
  always_comb begin
    level_nxt = level;
    slot0_nxt = slot0;
    slot1_nxt = slot1;
    if (flush_i) begin
      level_nxt = LVL_EMPTY;
    end else begin
      case (level)
        LVL_EMPTY: begin
          if (pop) begin
            level_nxt = LVL_ONE;
            slot0_nxt = fifo_data_i;
          end
        end
        LVL_ONE: begin
          if (pop && cons) begin
            slot0_nxt = fifo_data_i;
          end else if (pop) begin
            level_nxt = LVL_TWO;
            slot1_nxt = fifo_data_i;
          end else if (cons) begin
            level_nxt = LVL_EMPTY;
          end
        end
        LVL_TWO: begin
          if (cons) begin
            level_nxt = LVL_ONE;
            slot0_nxt = slot1;
          end
        end
        default: begin
          level_nxt = LVL_EMPTY;
        end
      endcase
    end
  end

  // Occupancy and slot registers; reset drops any held beats immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= LVL_EMPTY;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      level <= level_nxt;
      slot0 <= slot0_nxt;
      slot1 <= slot1_nxt;
    end
  end

  // Accepted-beat counter, free-running modulo 2^CNT_WIDTH; a beat accepted
  // during a flush cycle still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (cons) begin
      xfer_cnt <= xfer_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fifo_rd_skid.sv
// Bench for fifo_rd_skid paired with a small depth-4 fifo model.
module tb_fifo_rd_skid;

  logic        clk;
  logic        rst_n;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        fifo_r_en;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [1:0]  level;
  logic [3:0]  xfer_cnt;

  logic        push;
  logic [31:0] push_data;

  int checks   = 0;
  int failures = 0;

  fifo_rd_skid #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty_i (fifo_empty),
    .fifo_data_i  (fifo_data),
    .fifo_r_en_o  (fifo_r_en),
    .flush_i      (flush),
    .out_valid_o  (out_valid),
    .out_data_o   (out_data),
    .out_ready_i  (out_ready),
    .level_o      (level),
    .xfer_cnt_o   (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Depth-4 synchronous fifo model with a sticky underflow flag.
  logic [31:0] mem [4];
  logic [1:0]  wp, rp;
  logic [2:0]  fcount;
  logic        underflow;
  logic        push_ok, pop_ok;

  assign fifo_empty = (fcount == 3'd0);
  assign fifo_data  = mem[rp];
  assign push_ok    = push && (fcount != 3'd4);
  assign pop_ok     = fifo_r_en && (fcount != 3'd0);

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 32'h0;
    underflow = 1'b0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp     <= 2'd0;
      rp     <= 2'd0;
      fcount <= 3'd0;
    end else begin
      if (push_ok) begin
        mem[wp] <= push_data;
        wp      <= wp + 2'd1;
      end
      if (pop_ok) rp <= rp + 2'd1;
      fcount <= fcount + {2'b0, push_ok} - {2'b0, pop_ok};
    end
  end

  always @(posedge clk) begin
    if (rst_n && fifo_r_en && fcount == 3'd0) underflow <= 1'b1;
  end

  typedef struct {
    logic        push;
    logic [31:0] pdata;
    logic        ready;
    logic        flush;
    logic        e_ren;
    logic        e_valid;
    logic [31:0] e_data;
    logic [1:0]  e_level;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic v(input logic p, input logic [31:0] pd, input logic r, input logic f,
                   input logic ren, input logic val, input logic [31:0] d,
                   input logic [1:0] l, input logic [3:0] c);
    vec_t e;
    e.push = p; e.pdata = pd; e.ready = r; e.flush = f;
    e.e_ren = ren; e.e_valid = val; e.e_data = d; e.e_level = l; e.e_cnt = c;
    vecs.push_back(e);
  endtask

  task automatic drive(input logic p, input logic [31:0] pd, input logic r, input logic f);
    @(posedge clk);
    #1;
    push = p; push_data = pd; out_ready = r; flush = f;
  endtask

  initial begin
    int got;
    logic [31:0] exp_q[$];

    push = 0; push_data = 0; out_ready = 0; flush = 0;
    rst_n = 0;

    // Reset-state outputs.
    repeat (2) @(negedge clk);
    chk("rst_ren",   {31'b0, fifo_r_en}, 0);
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_data",  out_data, 0);
    chk("rst_level", {30'b0, level}, 0);
    chk("rst_cnt",   {28'b0, xfer_cnt}, 0);
    @(posedge clk); #1; rst_n = 1;

    // Idle after reset with fifo empty.
    v(0, 0, 1, 0, 0, 0, 0, 0, 0);
    v(0, 0, 1, 0, 0, 0, 0, 0, 0);
    // Single beat 0xA1.
    v(1, 32'hA1, 1, 0, 0, 0, 0, 0, 0);
    v(0, 0, 1, 0, 1, 0, 0, 0, 0);
    v(0, 0, 1, 0, 0, 1, 32'hA1, 1, 0);
    v(0, 0, 1, 0, 0, 0, 32'hA1, 0, 1);
    // Back-to-back stream 0x10..0x13 with ready high.
    v(1, 32'h10, 1, 0, 0, 0, 32'hA1, 0, 1);
    v(1, 32'h11, 1, 0, 1, 0, 32'hA1, 0, 1);
    v(1, 32'h12, 1, 0, 1, 1, 32'h10, 1, 1);
    v(1, 32'h13, 1, 0, 1, 1, 32'h11, 1, 2);
    v(0, 0, 1, 0, 1, 1, 32'h12, 1, 3);
    v(0, 0, 1, 0, 0, 1, 32'h13, 1, 4);
    v(0, 0, 1, 0, 0, 0, 32'h13, 0, 5);
    // Stall: fill to TWO, then drain 0x20..0x23.
    v(1, 32'h20, 0, 0, 0, 0, 32'h13, 0, 5);
    v(1, 32'h21, 0, 0, 1, 0, 32'h13, 0, 5);
    v(1, 32'h22, 0, 0, 1, 1, 32'h20, 1, 5);
    v(1, 32'h23, 0, 0, 0, 1, 32'h20, 2, 5);
    v(0, 0, 0, 0, 0, 1, 32'h20, 2, 5);
    v(0, 0, 1, 0, 0, 1, 32'h20, 2, 5);
    v(0, 0, 1, 0, 1, 1, 32'h21, 1, 6);
    v(0, 0, 1, 0, 1, 1, 32'h22, 1, 7);
    v(0, 0, 1, 0, 0, 1, 32'h23, 1, 8);
    v(0, 0, 1, 0, 0, 0, 32'h23, 0, 9);
    // Flush at TWO; remaining fifo entries follow in order.
    v(1, 32'h30, 0, 0, 0, 0, 32'h23, 0, 9);
    v(1, 32'h31, 0, 0, 1, 0, 32'h23, 0, 9);
    v(1, 32'h32, 0, 0, 1, 1, 32'h30, 1, 9);
    v(1, 32'h33, 0, 0, 0, 1, 32'h30, 2, 9);
    v(0, 0, 0, 1, 0, 1, 32'h30, 2, 9);
    v(0, 0, 0, 0, 1, 0, 32'h30, 0, 9);
    v(0, 0, 1, 0, 1, 1, 32'h32, 1, 9);
    v(0, 0, 1, 0, 0, 1, 32'h33, 1, 10);
    v(0, 0, 1, 0, 0, 0, 32'h33, 0, 11);
    // Flush in a cycle where the head beat is also accepted.
    v(1, 32'h40, 0, 0, 0, 0, 32'h33, 0, 11);
    v(0, 0, 0, 0, 1, 0, 32'h33, 0, 11);
    v(0, 0, 1, 1, 0, 1, 32'h40, 1, 11);
    v(0, 0, 1, 0, 0, 0, 32'h40, 0, 12);

    foreach (vecs[i]) begin
      drive(vecs[i].push, vecs[i].pdata, vecs[i].ready, vecs[i].flush);
      @(negedge clk);
      chk($sformatf("row%0d_ren", i),   {31'b0, fifo_r_en}, {31'b0, vecs[i].e_ren});
      chk($sformatf("row%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_valid});
      chk($sformatf("row%0d_data", i),  out_data, vecs[i].e_data);
      chk($sformatf("row%0d_level", i), {30'b0, level}, {30'b0, vecs[i].e_level});
      chk($sformatf("row%0d_cnt", i),   {28'b0, xfer_cnt}, {28'b0, vecs[i].e_cnt});
    end

    // Counter wrap: five more accepted beats bring the total to 17.
    got = 0;
    for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
      if (cyc < 5) begin
        drive(1, 32'h50 + cyc, 1, 0);
        exp_q.push_back(32'h50 + cyc);
      end else begin
        drive(0, 0, 1, 0);
      end
      @(negedge clk);
      if (out_valid && out_ready) begin
        chk($sformatf("wrap_beat%0d", got), out_data,
            (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF);
        got++;
      end
    end
    if (got != 5) chk("wrap_timeout_beats", got, 5);
    drive(0, 0, 1, 0);
    @(negedge clk);
    chk("wrap_cnt",   {28'b0, xfer_cnt}, 1);
    chk("wrap_valid", {31'b0, out_valid}, 0);

    // Asynchronous reset while holding two beats.
    drive(1, 32'h60, 0, 0);
    drive(1, 32'h61, 0, 0);
    drive(1, 32'h62, 0, 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("pre_arst_level", {30'b0, level}, 2);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 0);
    chk("arst_level", {30'b0, level}, 0);
    chk("arst_cnt",   {28'b0, xfer_cnt}, 0);
    chk("arst_ren",   {31'b0, fifo_r_en}, 0);
    drive(0, 0, 1, 0);
    rst_n = 1;
    @(negedge clk);
    chk("post_arst_ren",   {31'b0, fifo_r_en}, 0);
    chk("post_arst_valid", {31'b0, out_valid}, 0);

    chk("no_underflow", {31'b0, underflow}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
